hash_arbiter: RTL

//  Shares one hash core among NUM_REQ requesters (lookup/update stages) by round-robin.

---
 rtl/hash_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin front end for a single shared hash core.
// Grants one requester at a time, launches the core with the winner's key,
// waits for the core's ready and returns the value as a one-cycle ack. A
// watchdog aborts the operation with an err pulse if the core never answers.
module hash_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = 64,
  parameter int VAL_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*KEY_W-1:0] key_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic [VAL_W-1:0]         val_o,
  output logic                     busy_o,
  output logic                     hash_start_o,
  output logic [KEY_W-1:0]         hash_key_o,
  input  logic                     hash_ready_i,
  input  logic [VAL_W-1:0]         hash_val_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ABORT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [CNT_W-1:0] wait_cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] rr_next;

  // Round-robin pick: scan downward so the last hit is the one closest to rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_next = (grant == IDX_LAST) ? '0 : grant + IDX_W'(1);

  // Main sequencer: grant, launch, wait with watchdog, then report ack or err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      wait_cnt     <= '0;
      ack_o        <= '0;
      err_o        <= '0;
      val_o        <= '0;
      busy_o       <= 1'b0;
      hash_start_o <= 1'b0;
      hash_key_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= '0;
          err_o <= '0;
          if (pick_valid) begin
            grant        <= pick_idx;
            hash_key_o   <= key_i[pick_idx*KEY_W +: KEY_W];
            hash_start_o <= 1'b1;
            busy_o       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          hash_start_o <= 1'b0;
          wait_cnt     <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (hash_ready_i) begin
            val_o <= hash_val_i;
            ack_o <= ONE_HOT0 << grant;
            state <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            val_o <= '0;
            err_o <= ONE_HOT0 << grant;
            state <= ABORT;
          end
        end
        RESP, ABORT: begin
          ack_o  <= '0;
          err_o  <= '0;
          busy_o <= 1'b0;
          rr_ptr <= rr_next;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
